// File: rtl/jk_ctrl_pkg.sv
// Shared definitions for the JK bank controller: op codes, FSM states and
// the per-flop next-state rule used to form the response bit.
package jk_ctrl_pkg;

  // Op codes are the {J,K} pair applied to the addressed flop.
  localparam logic [1:0] OP_HOLD   = 2'b00;
  localparam logic [1:0] OP_RESET  = 2'b01;
  localparam logic [1:0] OP_SET    = 2'b10;
  localparam logic [1:0] OP_TOGGLE = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_APPLY = 2'b01,
    ST_RESP  = 2'b10
  } state_t;

  // Q a JK flop will hold after one edge with {J,K} = op.
  // A toggle loads the present Qbar.
  function automatic logic jk_next(input logic [1:0] op, input logic q,
                                   input logic qbar);
    case (op)
      OP_HOLD:  return q;
      OP_RESET: return 1'b0;
      OP_SET:   return 1'b1;
      default:  return qbar;
    endcase
  endfunction

endpackage

// File: rtl/jk_bank.sv
// Bank of N_FF JK flip-flops sharing one clock and an async active-high reset.
module jk_bank #(
  parameter int N_FF = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N_FF-1:0] i_j,
  input  logic [N_FF-1:0] i_k,
  output logic [N_FF-1:0] o_q,
  output logic [N_FF-1:0] o_qbar
);

  logic [N_FF-1:0] r_q;

  // Characteristic JK equation applied bitwise: Q+ = J&~Q | ~K&Q.
  // NOTE: every flop in the bank is reset; this is flop storage, not a RAM, so
  // clearing it costs nothing and the controller relies on a known-zero bank.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      // NOTE: sequential state uses <= so all flops sample pre-edge values.
      r_q <= '0;
    end else begin
      r_q <= (i_j & ~r_q) | (~i_k & r_q);
    end
  end

  assign o_q    = r_q;
  assign o_qbar = ~r_q;

endmodule

// File: rtl/jk_bank_ctrl.sv
// Two-requester round-robin controller that owns a JK flop bank. Each accepted
// command drives J/K of one flop for a single cycle, then returns its new Q.
module jk_bank_ctrl
  import jk_ctrl_pkg::*;
#(
  parameter int N_FF  = 8,
  parameter int IDX_W = $clog2(N_FF)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [1:0]       req0_op,
  input  logic [IDX_W-1:0] req0_idx,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [1:0]       req1_op,
  input  logic [IDX_W-1:0] req1_idx,
  output logic             rsp_valid,
  output logic             rsp_id,
  output logic             rsp_q,
  output logic             busy,
  output logic [N_FF-1:0]  q_bank
);

  state_t           r_state;
  logic             r_last_grant;
  logic [1:0]       r_op;
  logic [IDX_W-1:0] r_idx;
  logic             r_id;
  logic             r_rsp_valid;
  logic             r_rsp_id;
  logic             r_rsp_q;

  logic             w_any_valid;
  logic             w_grant_id;
  logic [N_FF-1:0]  w_j;
  logic [N_FF-1:0]  w_k;
  logic [N_FF-1:0]  w_q;
  logic [N_FF-1:0]  w_qbar;

  // Round-robin pick: a lone requester wins; on contention the one that did
  // not win last time gets the grant.
  assign w_any_valid = req0_valid | req1_valid;
  assign w_grant_id  = (req0_valid && req1_valid) ? ~r_last_grant : req1_valid;

  // Readies are held low while reset is asserted so no handshake can complete
  // against a controller that is being cleared.
  assign req0_ready = !rst && (r_state == ST_IDLE) && !w_grant_id && req0_valid;
  assign req1_ready = !rst && (r_state == ST_IDLE) &&  w_grant_id && req1_valid;

  // One-hot J/K for the latched flop during APPLY; every other flop holds.
  always_comb begin
    // NOTE: defaults first so no path through this block leaves a latch.
    w_j = '0;
    w_k = '0;
    if (r_state == ST_APPLY) begin
      w_j[r_idx] = r_op[1];
      w_k[r_idx] = r_op[0];
    end
  end

  jk_bank #(.N_FF(N_FF)) u_bank (
    .clk    (clk),
    .rst    (rst),
    .i_j    (w_j),
    .i_k    (w_k),
    .o_q    (w_q),
    .o_qbar (w_qbar)
  );

  // Command FSM: IDLE grants and latches, APPLY pulses J/K and pre-computes
  // the post-edge Q so the response register is exact in RESP.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= ST_IDLE;
      r_last_grant <= 1'b1;
      r_op         <= OP_HOLD;
      r_idx        <= '0;
      r_id         <= 1'b0;
      r_rsp_valid  <= 1'b0;
      r_rsp_id     <= 1'b0;
      r_rsp_q      <= 1'b0;
    end else begin
      r_rsp_valid <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_any_valid) begin
            r_state      <= ST_APPLY;
            r_last_grant <= w_grant_id;
            r_id         <= w_grant_id;
            r_op         <= w_grant_id ? req1_op  : req0_op;
            r_idx        <= w_grant_id ? req1_idx : req0_idx;
          end
        end
        ST_APPLY: begin
          r_state     <= ST_RESP;
          r_rsp_valid <= 1'b1;
          r_rsp_id    <= r_id;
          r_rsp_q     <= jk_next(r_op, w_q[r_idx], w_qbar[r_idx]);
        end
        ST_RESP: begin
          r_state <= ST_IDLE;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign rsp_valid = r_rsp_valid;
  assign rsp_id    = r_rsp_id;
  assign rsp_q     = r_rsp_q;
  assign busy      = (r_state != ST_IDLE);
  assign q_bank    = w_q;

endmodule

// File: tb/tb_jk_bank_ctrl.sv
// Self-checking bench for jk_bank_ctrl: directed scenarios with constant
// expectations, then a randomized run against a transaction-level model.
module tb_jk_bank_ctrl;

  localparam int N_FF = 8;
  localparam logic [1:0] HOLD = 2'b00, RST = 2'b01, SET = 2'b10, TOG = 2'b11;

  logic       clk;
  logic       rst;
  logic       req0_valid, req1_valid;
  logic       req0_ready, req1_ready;
  logic [1:0] req0_op, req1_op;
  logic [2:0] req0_idx, req1_idx;
  logic       rsp_valid, rsp_id, rsp_q, busy;
  logic [7:0] q_bank;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  jk_bank_ctrl #(.N_FF(N_FF)) dut (
    .clk        (clk),
    .rst        (rst),
    .req0_valid (req0_valid),
    .req0_ready (req0_ready),
    .req0_op    (req0_op),
    .req0_idx   (req0_idx),
    .req1_valid (req1_valid),
    .req1_ready (req1_ready),
    .req1_op    (req1_op),
    .req1_idx   (req1_idx),
    .rsp_valid  (rsp_valid),
    .rsp_id     (rsp_id),
    .rsp_q      (rsp_q),
    .busy       (busy),
    .q_bank     (q_bank)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input bit id, input bit v, input logic [1:0] op,
                       input logic [2:0] idx);
    if (id) begin
      req1_valid = v; req1_op = op; req1_idx = idx;
    end else begin
      req0_valid = v; req0_op = op; req0_idx = idx;
    end
  endtask

  // Called at posedge+1; returns at posedge+1 with the controller idle.
  task automatic apply_reset();
    rst = 1'b1;
    #3;
    rst = 1'b0;
    tick();
  endtask

  // Issues one command and measures its handshake/response timing.
  task automatic issue(input bit id, input logic [1:0] op, input logic [2:0] idx,
                       output bit ok, output bit got_id, output bit got_q,
                       output logic [7:0] got_bank, output int acc_cyc);
    int n;
    bit seen;
    logic [7:0] bank_t;
    ok = 1'b1; seen = 1'b0; n = 0;
    got_id = 1'b0; got_q = 1'b0; got_bank = 'x; acc_cyc = -1;
    drive(id, 1'b1, op, idx);
    while (!seen && n < 20) begin
      @(negedge clk);
      if ((id ? req1_ready : req0_ready) === 1'b1) seen = 1'b1;
      else begin n++; tick(); end
    end
    if (!seen) begin
      ok = 1'b0;
      drive(id, 1'b0, op, idx);
      tick();
    end else begin
      acc_cyc = cyc;
      bank_t  = q_bank;
      if (busy !== 1'b0 || rsp_valid !== 1'b0) ok = 1'b0;
      tick();
      drive(id, 1'b0, op, idx);
      @(negedge clk);
      if (busy !== 1'b1 || rsp_valid !== 1'b0 || q_bank !== bank_t ||
          req0_ready !== 1'b0 || req1_ready !== 1'b0) ok = 1'b0;
      @(negedge clk);
      if (busy !== 1'b1 || rsp_valid !== 1'b1) ok = 1'b0;
      got_id = rsp_id; got_q = rsp_q; got_bank = q_bank;
      tick();
      if (busy !== 1'b0 || rsp_valid !== 1'b0) ok = 1'b0;
    end
  endtask

  task automatic test_reset();
    int n;
    bit seen;
    rst = 1'b1;
    drive(0, 1'b1, SET, 3'd3);
    drive(1, 1'b1, TOG, 3'd6);
    #12;
    checks++; if (q_bank !== 8'h00) begin errors++; $display("FAIL reset_bank: got %h expected 00", q_bank); end
    checks++; if (rsp_valid !== 1'b0 || rsp_id !== 1'b0 || rsp_q !== 1'b0) begin errors++; $display("FAIL reset_rsp: got v=%b id=%b q=%b expected 0 0 0", rsp_valid, rsp_id, rsp_q); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
    checks++; if (req0_ready !== 1'b0 || req1_ready !== 1'b0) begin errors++; $display("FAIL reset_ready: got %b%b expected 00", req0_ready, req1_ready); end
    drive(0, 1'b0, SET, 3'd3);
    drive(1, 1'b0, TOG, 3'd6);
    rst = 1'b0;
    tick();
    // Asynchronous reset while a response is on the bus.
    drive(1, 1'b1, TOG, 3'd6);
    seen = 1'b0; n = 0;
    while (!seen && n < 20) begin
      @(negedge clk);
      if (req1_ready === 1'b1) seen = 1'b1; else begin n++; tick(); end
    end
    checks++; if (!seen) begin errors++; $display("FAIL reset_pre_accept: got no ready expected ready"); end
    tick();
    drive(1, 1'b0, TOG, 3'd6);
    tick();
    #2;
    checks++; if (rsp_valid !== 1'b1 || q_bank !== 8'h40) begin errors++; $display("FAIL reset_pre_resp: got v=%b bank=%h expected 1 40", rsp_valid, q_bank); end
    rst = 1'b1;
    #1;
    checks++; if (q_bank !== 8'h00 || rsp_valid !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL reset_async: got bank=%h v=%b busy=%b expected 00 0 0", q_bank, rsp_valid, busy); end
    #1;
    rst = 1'b0;
    tick();
  endtask

  task automatic test_single_set();
    bit ok, id, q; logic [7:0] b; int c;
    issue(0, SET, 3'd3, ok, id, q, b, c);
    checks++; if (ok !== 1'b1) begin errors++; $display("FAIL set_timing: got bad timing expected 3-cycle sequence"); end
    checks++; if (id !== 1'b0 || q !== 1'b1) begin errors++; $display("FAIL set_rsp: got id=%b q=%b expected 0 1", id, q); end
    checks++; if (b !== 8'h08) begin errors++; $display("FAIL set_bank: got %h expected 08", b); end
  endtask

  task automatic test_toggle();
    bit ok1, ok2, id1, id2, q1, q2; logic [7:0] b1, b2; int c1, c2;
    apply_reset();
    issue(1, TOG, 3'd0, ok1, id1, q1, b1, c1);
    issue(1, TOG, 3'd0, ok2, id2, q2, b2, c2);
    checks++; if (ok1 !== 1'b1 || ok2 !== 1'b1) begin errors++; $display("FAIL tog_timing: got %b%b expected 11", ok1, ok2); end
    checks++; if (id1 !== 1'b1 || q1 !== 1'b1 || b1 !== 8'h01) begin errors++; $display("FAIL tog_first: got id=%b q=%b bank=%h expected 1 1 01", id1, q1, b1); end
    checks++; if (id2 !== 1'b1 || q2 !== 1'b0 || b2 !== 8'h00) begin errors++; $display("FAIL tog_second: got id=%b q=%b bank=%h expected 1 0 00", id2, q2, b2); end
    checks++; if (c2 - c1 !== 3) begin errors++; $display("FAIL tog_spacing: got %0d expected 3", c2 - c1); end
  endtask

  task automatic test_arbitration();
    bit grants[$]; bit rids[$]; bit both; logic [7:0] bank2;
    bit ok, id, q; logic [7:0] b; int c;
    apply_reset();
    both = 1'b0; bank2 = 'x;
    drive(0, 1'b1, SET, 3'd1);
    drive(1, 1'b1, SET, 3'd2);
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (req0_ready === 1'b1 && req1_ready === 1'b1) both = 1'b1;
      if (req0_ready === 1'b1) grants.push_back(1'b0);
      if (req1_ready === 1'b1) grants.push_back(1'b1);
      if (rsp_valid === 1'b1) begin
        rids.push_back(rsp_id);
        if (rids.size() == 2) bank2 = q_bank;
      end
      tick();
    end
    drive(0, 1'b0, SET, 3'd1);
    drive(1, 1'b0, SET, 3'd2);
    checks++; if (both !== 1'b0) begin errors++; $display("FAIL arb_exclusive: got both readys expected one"); end
    checks++; if (grants.size() !== 4 || rids.size() !== 4) begin errors++; $display("FAIL arb_count: got %0d grants %0d rsps expected 4 4", grants.size(), rids.size()); end
    for (int i = 0; i < grants.size() && i < rids.size(); i++) begin
      checks++;
      if (grants[i] !== i[0] || rids[i] !== i[0]) begin errors++; $display("FAIL arb_order[%0d]: got grant=%b rsp_id=%b expected %b", i, grants[i], rids[i], i[0]); end
    end
    checks++; if (bank2 !== 8'h06) begin errors++; $display("FAIL arb_bank: got %h expected 06", bank2); end
    issue(0, HOLD, 3'd1, ok, id, q, b, c);
    checks++; if (ok !== 1'b1 || q !== 1'b1 || b !== 8'h06) begin errors++; $display("FAIL arb_hold1: got ok=%b q=%b bank=%h expected 1 1 06", ok, q, b); end
    issue(1, HOLD, 3'd0, ok, id, q, b, c);
    checks++; if (ok !== 1'b1 || id !== 1'b1 || q !== 1'b0 || b !== 8'h06) begin errors++; $display("FAIL arb_hold0: got ok=%b id=%b q=%b bank=%h expected 1 1 0 06", ok, id, q, b); end
  endtask

  task automatic test_reset_apply();
    int n; bit seen, pulsed, r0, r1;
    drive(0, 1'b1, SET, 3'd5);
    seen = 1'b0; n = 0;
    while (!seen && n < 20) begin
      @(negedge clk);
      if (req0_ready === 1'b1) seen = 1'b1; else begin n++; tick(); end
    end
    checks++; if (!seen) begin errors++; $display("FAIL rst_apply_accept: got no ready expected ready"); end
    tick();
    drive(0, 1'b0, SET, 3'd5);
    #2;
    rst = 1'b1;
    #2;
    rst = 1'b0;
    pulsed = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (rsp_valid !== 1'b0) pulsed = 1'b1;
    end
    tick();
    checks++; if (pulsed !== 1'b0) begin errors++; $display("FAIL rst_apply_rsp: got a response expected none"); end
    checks++; if (q_bank !== 8'h00) begin errors++; $display("FAIL rst_apply_bank: got %h expected 00", q_bank); end
    drive(0, 1'b1, SET, 3'd4);
    drive(1, 1'b1, SET, 3'd6);
    @(negedge clk);
    r0 = req0_ready; r1 = req1_ready;
    checks++; if (r0 !== 1'b1 || r1 !== 1'b0) begin errors++; $display("FAIL rst_apply_prio: got %b%b expected 10", r0, r1); end
    tick();
    drive(0, 1'b0, SET, 3'd4);
    tick();
    tick();
    @(negedge clk);
    r0 = req0_ready; r1 = req1_ready;
    checks++; if (r0 !== 1'b0 || r1 !== 1'b1) begin errors++; $display("FAIL rst_apply_rr: got %b%b expected 01", r0, r1); end
    tick();
    drive(1, 1'b0, SET, 3'd6);
    tick();
    tick();
  endtask

  task automatic test_hold_reset();
    bit ok, id, q; logic [7:0] b0, b1, b2; int c;
    issue(0, SET, 3'd7, ok, id, q, b0, c);
    checks++; if (ok !== 1'b1 || q !== 1'b1 || b0[7] !== 1'b1) begin errors++; $display("FAIL hr_preset: got ok=%b q=%b bank=%h expected bit7 set", ok, q, b0); end
    issue(0, HOLD, 3'd7, ok, id, q, b1, c);
    checks++; if (ok !== 1'b1 || q !== 1'b1 || b1 !== b0) begin errors++; $display("FAIL hr_hold: got ok=%b q=%b bank=%h expected 1 1 %h", ok, q, b1, b0); end
    issue(0, RST, 3'd7, ok, id, q, b2, c);
    checks++; if (ok !== 1'b1 || q !== 1'b0 || b2 !== (b0 & 8'h7f)) begin errors++; $display("FAIL hr_reset: got ok=%b q=%b bank=%h expected 1 0 %h", ok, q, b2, b0 & 8'h7f); end
  endtask

  // Randomized traffic checked every cycle against a transaction model:
  // accepts only when no command is in flight, new Q one edge after accept,
  // response in the cycle after that, round-robin on contention.
  task automatic test_random();
    bit pv[2]; logic [1:0] pop[2]; logic [2:0] pidx[2];
    bit m_bank[N_FF];
    bit m_last, m_id, win, e_r0, e_r1;
    int m_phase;
    logic [1:0] m_op; logic [2:0] m_idx; logic [7:0] e_bank;
    apply_reset();
    for (int i = 0; i < N_FF; i++) m_bank[i] = 1'b0;
    pv[0] = 0; pv[1] = 0; pop[0] = 0; pop[1] = 0; pidx[0] = 0; pidx[1] = 0;
    m_last = 1'b1; m_phase = 0; m_id = 0; m_op = 0; m_idx = 0;
    for (int t = 0; t < 600; t++) begin
      for (int r = 0; r < 2; r++) begin
        if (!pv[r]) begin
          if ($urandom_range(0, 99) < 50) begin
            pv[r] = 1'b1; pop[r] = 2'($urandom); pidx[r] = 3'($urandom);
          end
        end else if ($urandom_range(0, 99) < 8) pv[r] = 1'b0;
      end
      drive(0, pv[0], pop[0], pidx[0]);
      drive(1, pv[1], pop[1], pidx[1]);
      @(negedge clk);
      e_r0 = 1'b0; e_r1 = 1'b0; win = 1'b0;
      if (m_phase == 0 && (pv[0] || pv[1])) begin
        win  = (pv[0] && pv[1]) ? ~m_last : pv[1];
        e_r0 = ~win; e_r1 = win;
      end
      for (int i = 0; i < N_FF; i++) e_bank[i] = m_bank[i];
      checks++; if (req0_ready !== e_r0 || req1_ready !== e_r1) begin errors++; $display("FAIL rnd_ready t=%0d: got %b%b expected %b%b", t, req0_ready, req1_ready, e_r0, e_r1); end
      checks++; if (busy !== (m_phase != 0)) begin errors++; $display("FAIL rnd_busy t=%0d: got %b expected %b", t, busy, m_phase != 0); end
      checks++; if (rsp_valid !== (m_phase == 2)) begin errors++; $display("FAIL rnd_rsp_valid t=%0d: got %b expected %b", t, rsp_valid, m_phase == 2); end
      checks++; if (q_bank !== e_bank) begin errors++; $display("FAIL rnd_bank t=%0d: got %h expected %h", t, q_bank, e_bank); end
      if (m_phase == 2) begin
        checks++; if (rsp_id !== m_id || rsp_q !== m_bank[m_idx]) begin errors++; $display("FAIL rnd_rsp t=%0d: got id=%b q=%b expected %b %b", t, rsp_id, rsp_q, m_id, m_bank[m_idx]); end
      end
      if (m_phase == 1) begin
        case (m_op)
          RST:     m_bank[m_idx] = 1'b0;
          SET:     m_bank[m_idx] = 1'b1;
          TOG:     m_bank[m_idx] = ~m_bank[m_idx];
          default: ;
        endcase
        m_phase = 2;
      end else if (m_phase == 2) begin
        m_phase = 0;
      end else if (e_r0 || e_r1) begin
        m_last = win; m_id = win; m_op = pop[win]; m_idx = pidx[win];
        pv[win] = 1'b0;
        m_phase = 1;
      end
      tick();
    end
    drive(0, 1'b0, HOLD, 3'd0);
    drive(1, 1'b0, HOLD, 3'd0);
  endtask

  initial begin
    rst = 1'b0;
    drive(0, 1'b0, HOLD, 3'd0);
    drive(1, 1'b0, HOLD, 3'd0);
    test_reset();
    test_single_set();
    test_toggle();
    test_arbitration();
    test_reset_apply();
    test_hold_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/jk_bank_ctrl.md
Name: jk_bank_ctrl

Overview:
Controller that shares a bank of JK flip-flops between two requesters. Each requester issues {op, idx} commands over a valid/ready handshake. A round-robin arbiter grants one command at a time. The FSM drives the J/K pair of the addressed flop for exactly one cycle, then returns that flop's new Q to the winner. The block sits between software-style command sources and the JK storage bank, and owns the bank.

Parameters:
- N_FF, 8, number of JK flip-flops in the bank; must be a power of two, ≥2.
- IDX_W, $clog2(N_FF), width of flop index.

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-high reset.
- req0_valid  in  1  requester 0 command valid.
- req0_ready  out  1  requester 0 command accepted this cycle.
- req0_op  in  2  requester 0 op, {J,K}: 00 hold, 01 reset, 10 set, 11 toggle.
- req0_idx  in  IDX_W  requester 0 target flop.
- req1_valid, req1_ready, req1_op, req1_idx  as above, for requester 1.
- rsp_valid  out  1  one-cycle response pulse.
- rsp_id  out  1  requester that owns the response (0/1).
- rsp_q  out  1  Q of the addressed flop after the command.
- busy  out  1  high whenever state != IDLE.
- q_bank  out  N_FF  live Q of every flop.

Behaviour:
- Reset (async, rst=1): state=IDLE, bank Q all 0 (Qbar all 1), rsp_valid=0, rsp_id=0, rsp_q=0, busy=0, last_grant=1, so requester 0 wins first. Both readys are 0 while rst=1.
- FSM states:
  - IDLE: if any valid, grant and go to APPLY.
  - APPLY: go to RESP unconditionally.
  - RESP: go to IDLE unconditionally.
- Arbitration (IDLE only):
  - Only one valid: grant it.
  - Both valid: grant the requester ≠ last_grant.
  - On grant, update last_grant and latch op, idx and id.
- reqN_ready is combinational: (state==IDLE) && grant==N && reqN_valid. The handshake completes on the edge where valid and ready are both high.
- Requesters hold valid, op and idx stable until ready. Commands with valid=0 are ignored. Deasserting valid before ready is legal: the command is withdrawn.
- APPLY: J/K of the latched idx equal the latched op for this one cycle. All other flops see J=K=0 (hold). The bank updates on the edge ending APPLY.
- RESP: rsp_valid=1, rsp_id=latched id, rsp_q=q_bank[idx] (post-update). There is no backpressure on the response. At most one response is in flight.
- Timing:
  - Latency: accept edge at end of cycle t → Q changes at end of t+1 → rsp_valid high during t+2.
  - Throughput: one command per 3 cycles.
  - The next accept can occur in cycle t+3.
- rsp_q and rsp_id are held after the pulse and are valid only while rsp_valid=1.
- Op semantics per flop:
  - hold: Q unchanged.
  - reset: Q=0.
  - set: Q=1.
  - toggle: Q=~Q.
  - Hold still runs the full 3-cycle sequence and returns the unchanged Q.
- Both requesters targeting the same idx are serialized; the second sees the first's result.
- Reset mid-operation (any state) aborts the command. No response is produced, the bank clears, and arbitration restarts with requester 0 priority.
- q_bank is registered bank state, with no combinational path from inputs.

Decomposition:
- Package jk_ctrl_pkg:
  - op localparams OP_HOLD=2'b00, OP_RESET=2'b01, OP_SET=2'b10, OP_TOGGLE=2'b11.
  - FSM state encoding IDLE/APPLY/RESP.
- Sub-module jk_bank:
  - N_FF JK flops with N_FF-wide J and K vectors, clk, async rst.
  - Outputs q and qbar vectors.
  - The controller drives one-hot J/K from the latched op and idx.

Test Plan:
- Reset: assert rst mid-cycle → immediately q_bank=8'h00, rsp_valid=0, busy=0, req0_ready=req1_ready=0.
- Single set: req0 op=10 idx=3 accepted at cycle t → q_bank=8'h08 from t+2, rsp_valid=1 in t+2 with rsp_id=0, rsp_q=1; req0_ready high only in t.
- Toggle: req1 toggle idx=0 twice → first rsp_q=1 (q_bank=8'h01), second rsp_q=0 (q_bank=8'h00); accepts 3 cycles apart.
- Arbitration: both valid continuously, req0 set idx1, req1 set idx2 → grant order 0,1,0,1 with rsp_id alternating. After 2 responses q_bank=8'h06; hold op returns rsp_q matching the unchanged bit.
- Reset during APPLY: req0 set idx5 accepted, rst pulsed in APPLY → no rsp_valid pulse, q_bank=8'h00. The next simultaneous request is granted to requester 0.
- Hold/reset ops: preset idx7=1, then req0 op=00 idx7 → rsp_q=1 and q_bank unchanged. Then op=01 idx7 → rsp_q=0, bit7 cleared.
